// File: rtl/icache_pkg.sv
// Shared sizes and FSM encoding for the instruction cache.
package icache_pkg;

    // Address width of the instruction fetch path
    localparam int INSTRUCTION_ADDRESS_SIZE = 32;
    // Width of one instruction word
    localparam int INSTRUCTION_SIZE         = 32;
    // Line-index width (2**ICACHE_INDEX_SIZE lines of one word each)
    localparam int ICACHE_INDEX_SIZE        = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/data storage for the direct-mapped instruction cache.
// One combinational read port and one write port; only the valid bits are reset.
module icache_array #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_W      = 23,
    parameter int DATA_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [DATA_W-1:0]     wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid_q;

    // Tag and data RAM write; left unreset so it maps onto plain memory
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

    // Valid bits: cleared by reset, set by each line fill
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, single-word fill on miss.
// The response handshake toward IF is a 1-cycle pulse: icache_flag is high for exactly
// one cycle per served request and qualifies icache_instruction; IF holds if_read_flag/if_pc
// until it sees that pulse (or redirects with flush). Toward memory, instruction_read_flag
// is a level request that drops combinationally in the cycle instruction_flag returns the word.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_SIZE,
    parameter int ADDR_W     = INSTRUCTION_ADDRESS_SIZE,
    parameter int INSN_W     = INSTRUCTION_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read_flag,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              flush,
    output logic              icache_flag,
    output logic [INSN_W-1:0] icache_instruction,
    output logic              instruction_read_flag,
    output logic [ADDR_W-1:0] instruction_read_address,
    input  logic              instruction_flag,
    input  logic [INSN_W-1:0] instruction,
    output logic              dbg_state_o
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic              cancel_q, cancel_d;
    logic              flag_q, flag_d;
    logic [INSN_W-1:0] insn_q, insn_d;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [INSN_W-1:0] rd_data;
    logic              hit;
    logic              fill_we;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (INSN_W)
    ) u_array (
        .clk_i      (clk),
        .rst_ni     (rst),
        .rd_idx_i   (if_pc[INDEX_BITS+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_we),
        .wr_idx_i   (miss_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (miss_addr_q[ADDR_W-1:INDEX_BITS+2]),
        .wr_data_i  (instruction)
    );

    assign hit = rd_valid && (rd_tag == if_pc[ADDR_W-1:INDEX_BITS+2]);

    // State, miss address, cancel bit and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            cancel_q    <= 1'b0;
            flag_q      <= 1'b0;
            insn_q      <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            cancel_q    <= cancel_d;
            flag_q      <= flag_d;
            insn_q      <= insn_d;
        end
    end

    // Next-state: accept requests in IDLE, wait for the fill in MISS
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        cancel_d    = cancel_q;
        flag_d      = 1'b0;
        insn_d      = '0;
        fill_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // flush wins over a simultaneous request
                if (if_read_flag && !flush) begin
                    if (hit) begin
                        flag_d = 1'b1;
                        insn_d = rd_data;
                    end else begin
                        miss_addr_d = if_pc;
                        cancel_d    = 1'b0;
                        state_d     = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (flush) begin
                    cancel_d = 1'b1;
                end
                // The memory fetch cannot be aborted: always fill, only the reply is dropped
                if (instruction_flag) begin
                    fill_we  = 1'b1;
                    state_d  = ST_IDLE;
                    cancel_d = 1'b0;
                    if (!cancel_q && !flush) begin
                        flag_d = 1'b1;
                        insn_d = instruction;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: memory request is combinational so it drops in the return cycle
    always_comb begin
        instruction_read_flag    = 1'b0;
        instruction_read_address = '0;
        if (state_q == ST_MISS) begin
            instruction_read_flag    = !instruction_flag;
            instruction_read_address = miss_addr_q;
        end
    end

    assign icache_flag        = flag_q;
    assign icache_instruction = insn_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: each task drives one scenario and checks inline.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        if_read_flag;
    logic [31:0] if_pc;
    logic        flush;
    logic        icache_flag;
    logic [31:0] icache_instruction;
    logic        instruction_read_flag;
    logic [31:0] instruction_read_address;
    logic        instruction_flag;
    logic [31:0] instruction;
    logic        dbg_state;

    int n_checks;
    int n_fail;

    icache dut (
        .clk                      (clk),
        .rst                      (rst),
        .if_read_flag             (if_read_flag),
        .if_pc                    (if_pc),
        .flush                    (flush),
        .icache_flag              (icache_flag),
        .icache_instruction       (icache_instruction),
        .instruction_read_flag    (instruction_read_flag),
        .instruction_read_address (instruction_read_address),
        .instruction_flag         (instruction_flag),
        .instruction              (instruction),
        .dbg_state_o              (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_read_flag = 1'b0; if_pc = '0; flush = 1'b0;
        instruction_flag = 1'b0; instruction = '0;
        #2;
        n_checks++;
        if (icache_flag !== 1'b0 || icache_instruction !== 32'h0) begin
            n_fail++; $display("FAIL reset_out: flag=%b insn=%h expected 0/0", icache_flag, icache_instruction);
        end
        n_checks++;
        if (instruction_read_flag !== 1'b0 || instruction_read_address !== 32'h0 || dbg_state !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem: rf=%b ra=%h st=%b expected 0/0/0",
                               instruction_read_flag, instruction_read_address, dbg_state);
        end
        tick(); tick();
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        if_read_flag = 1'b1; if_pc = 32'h0;
        #1;
        n_checks++;
        if (instruction_read_flag !== 1'b0) begin
            n_fail++; $display("FAIL t1_idle_rf: got %b expected 0", instruction_read_flag);
        end
        tick();
        n_checks++;
        if (dbg_state !== 1'b1 || instruction_read_flag !== 1'b1 || instruction_read_address !== 32'h0 || icache_flag !== 1'b0) begin
            n_fail++; $display("FAIL t1_miss: st=%b rf=%b ra=%h flag=%b expected 1/1/0/0",
                               dbg_state, instruction_read_flag, instruction_read_address, icache_flag);
        end
        tick();
        n_checks++;
        if (instruction_read_flag !== 1'b1) begin
            n_fail++; $display("FAIL t1_rf_hold: got %b expected 1", instruction_read_flag);
        end
        instruction_flag = 1'b1; instruction = 32'h0000_0013;
        #1;
        n_checks++;
        if (instruction_read_flag !== 1'b0) begin
            n_fail++; $display("FAIL t1_rf_drop: got %b expected 0", instruction_read_flag);
        end
        tick();
        instruction_flag = 1'b0; instruction = '0; if_read_flag = 1'b0;
        n_checks++;
        if (icache_flag !== 1'b1 || icache_instruction !== 32'h0000_0013 || dbg_state !== 1'b0) begin
            n_fail++; $display("FAIL t1_resp: flag=%b insn=%h st=%b expected 1/00000013/0",
                               icache_flag, icache_instruction, dbg_state);
        end
        tick();
        n_checks++;
        if (icache_flag !== 1'b0 || icache_instruction !== 32'h0) begin
            n_fail++; $display("FAIL t1_pulse: flag=%b insn=%h expected 0/0", icache_flag, icache_instruction);
        end
    endtask

    task automatic test_hit();
        if_read_flag = 1'b1; if_pc = 32'h0;
        tick();
        if_read_flag = 1'b0;
        n_checks++;
        if (icache_flag !== 1'b1 || icache_instruction !== 32'h0000_0013 || instruction_read_flag !== 1'b0) begin
            n_fail++; $display("FAIL t2_hit: flag=%b insn=%h rf=%b expected 1/00000013/0",
                               icache_flag, icache_instruction, instruction_read_flag);
        end
        tick();
        n_checks++;
        if (icache_flag !== 1'b0 || instruction_read_flag !== 1'b0 || dbg_state !== 1'b0) begin
            n_fail++; $display("FAIL t2_after: flag=%b rf=%b st=%b expected 0/0/0",
                               icache_flag, instruction_read_flag, dbg_state);
        end
    endtask

    task automatic test_flush_idle();
        // pc 0 would hit; flush must block it
        if_read_flag = 1'b1; flush = 1'b1; if_pc = 32'h0;
        tick();
        if_read_flag = 1'b0; flush = 1'b0;
        n_checks++;
        if (icache_flag !== 1'b0 || dbg_state !== 1'b0 || instruction_read_flag !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: flag=%b st=%b rf=%b expected 0/0/0",
                               icache_flag, dbg_state, instruction_read_flag);
        end
    endtask

    task automatic test_stray_return();
        instruction_flag = 1'b1; instruction = 32'h5555_5555;
        tick();
        instruction_flag = 1'b0; instruction = '0;
        n_checks++;
        if (icache_flag !== 1'b0 || icache_instruction !== 32'h0 || dbg_state !== 1'b0) begin
            n_fail++; $display("FAIL stray: flag=%b insn=%h st=%b expected 0/0/0",
                               icache_flag, icache_instruction, dbg_state);
        end
    endtask

    task automatic test_conflict();
        if_read_flag = 1'b1; if_pc = 32'h0000_0200;
        tick();
        n_checks++;
        if (instruction_read_flag !== 1'b1 || instruction_read_address !== 32'h0000_0200) begin
            n_fail++; $display("FAIL t3_miss: rf=%b ra=%h expected 1/00000200",
                               instruction_read_flag, instruction_read_address);
        end
        instruction_flag = 1'b1; instruction = 32'hDEAD_BEEF;
        tick();
        instruction_flag = 1'b0; if_read_flag = 1'b0;
        n_checks++;
        if (icache_flag !== 1'b1 || icache_instruction !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL t3_resp: flag=%b insn=%h expected 1/deadbeef", icache_flag, icache_instruction);
        end
        tick();
        // pc 0 shares index 0 but the line now holds tag 1
        if_read_flag = 1'b1; if_pc = 32'h0;
        tick();
        n_checks++;
        if (instruction_read_flag !== 1'b1 || instruction_read_address !== 32'h0 || icache_flag !== 1'b0) begin
            n_fail++; $display("FAIL t3_evict: rf=%b ra=%h flag=%b expected 1/0/0",
                               instruction_read_flag, instruction_read_address, icache_flag);
        end
        instruction_flag = 1'b1; instruction = 32'h0000_0013;
        tick();
        instruction_flag = 1'b0; if_read_flag = 1'b0;
        n_checks++;
        if (icache_flag !== 1'b1 || icache_instruction !== 32'h0000_0013) begin
            n_fail++; $display("FAIL t3_refill: flag=%b insn=%h expected 1/00000013", icache_flag, icache_instruction);
        end
        tick();
    endtask

    task automatic test_flush_miss();
        if_read_flag = 1'b1; if_pc = 32'h0000_0104;
        tick();
        n_checks++;
        if (instruction_read_flag !== 1'b1 || instruction_read_address !== 32'h0000_0104) begin
            n_fail++; $display("FAIL t4_miss: rf=%b ra=%h expected 1/00000104",
                               instruction_read_flag, instruction_read_address);
        end
        flush = 1'b1; if_read_flag = 1'b0;
        tick();
        flush = 1'b0;
        n_checks++;
        if (instruction_read_flag !== 1'b1 || dbg_state !== 1'b1) begin
            n_fail++; $display("FAIL t4_hold: rf=%b st=%b expected 1/1", instruction_read_flag, dbg_state);
        end
        instruction_flag = 1'b1; instruction = 32'h1234_5678;
        tick();
        instruction_flag = 1'b0; instruction = '0;
        n_checks++;
        if (icache_flag !== 1'b0 || icache_instruction !== 32'h0 || dbg_state !== 1'b0) begin
            n_fail++; $display("FAIL t4_suppress: flag=%b insn=%h st=%b expected 0/0/0",
                               icache_flag, icache_instruction, dbg_state);
        end
        if_read_flag = 1'b1; if_pc = 32'h0000_0104;
        tick();
        if_read_flag = 1'b0;
        n_checks++;
        if (icache_flag !== 1'b1 || icache_instruction !== 32'h1234_5678 || instruction_read_flag !== 1'b0) begin
            n_fail++; $display("FAIL t4_hit: flag=%b insn=%h rf=%b expected 1/12345678/0",
                               icache_flag, icache_instruction, instruction_read_flag);
        end
        tick();
    endtask

    task automatic test_slow_memory();
        int pulses;
        int bad;
        pulses = 0;
        bad = 0;
        if_read_flag = 1'b1; if_pc = 32'h0000_0300;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (instruction_read_flag !== 1'b1 || instruction_read_address !== 32'h0000_0300 || icache_flag !== 1'b0) begin
                bad++;
            end
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL t5_wait: %0d bad cycles, expected 0 (last rf=%b ra=%h)",
                               bad, instruction_read_flag, instruction_read_address);
        end
        instruction_flag = 1'b1; instruction = 32'hCAFE_F00D;
        tick();
        instruction_flag = 1'b0; instruction = '0; if_read_flag = 1'b0;
        n_checks++;
        if (icache_instruction !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL t5_data: got %h expected cafef00d", icache_instruction);
        end
        if (icache_flag === 1'b1) pulses++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (icache_flag === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL t5_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_mid_miss();
        if_read_flag = 1'b1; if_pc = 32'h0000_0404;
        tick();
        n_checks++;
        if (instruction_read_flag !== 1'b1 || instruction_read_address !== 32'h0000_0404) begin
            n_fail++; $display("FAIL t6_miss: rf=%b ra=%h expected 1/00000404",
                               instruction_read_flag, instruction_read_address);
        end
        tick();
        #2 rst = 1'b0;
        if_read_flag = 1'b0;
        #1;
        n_checks++;
        if (instruction_read_flag !== 1'b0 || instruction_read_address !== 32'h0 || dbg_state !== 1'b0 ||
            icache_flag !== 1'b0 || icache_instruction !== 32'h0) begin
            n_fail++; $display("FAIL t6_async: rf=%b ra=%h st=%b flag=%b insn=%h expected all 0",
                               instruction_read_flag, instruction_read_address, dbg_state,
                               icache_flag, icache_instruction);
        end
        tick();
        #3 rst = 1'b1;
        tick();
        // valid bits were cleared, so a previously cached pc misses
        if_read_flag = 1'b1; if_pc = 32'h0;
        tick();
        n_checks++;
        if (instruction_read_flag !== 1'b1 || icache_flag !== 1'b0) begin
            n_fail++; $display("FAIL t6_remiss: rf=%b flag=%b expected 1/0", instruction_read_flag, icache_flag);
        end
        instruction_flag = 1'b1; instruction = 32'h0000_0013;
        tick();
        instruction_flag = 1'b0; if_read_flag = 1'b0;
        n_checks++;
        if (icache_flag !== 1'b1 || icache_instruction !== 32'h0000_0013) begin
            n_fail++; $display("FAIL t6_fill: flag=%b insn=%h expected 1/00000013", icache_flag, icache_instruction);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_flush_idle();
        test_stray_return();
        test_conflict();
        test_flush_miss();
        test_slow_memory();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
